fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decode/control stage. Holds the program counter, issues word requests to instruction memory over a valid/ready handshake, and buffers returned words in a small in-order FIFO. Presents `instruction` plus its PC to decode over a valid/ready handshake. Accepts a redirect (jump/branch target) that flushes the buffer and discards stale in-flight responses.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake bundle between the fetch stage, instruction memory,
// the redirect source and the decode stage.
//   imem_req_*   : request channel to instruction memory (valid/ready)
//   imem_resp_*  : in-order response channel, never back-pressured
//   redirect_*   : one-cycle redirect pulse and its target PC
//   instr_*      : FIFO head toward decode (valid/ready), with its PC
//   fetch_fault  : sticky misaligned-redirect flag
// master = the fetch unit, slave = its environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, issues word requests to
// instruction memory, buffers returned words in an in-order FIFO and presents
// the head word plus its PC to decode. A redirect flushes the FIFO, reloads
// the PC and discards every response still in flight at that point.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : fetch_unit_if.master (memory request/response, redirect,
//            decode handshake, fetch_fault)
//
// Parameters:
//   RESET_PC  : PC loaded on reset
//   BUF_DEPTH : FIFO entries and maximum requests in flight (power of two, >= 2)
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : misaligned redirect target sets sticky fetch_fault and stops issue
//   undefined : fetch_fault tied low, redirect_pc[1:0] forced to zero
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = BUF_DEPTH[CW:0];

  logic [31:0]   r_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_tag_wptr;
  logic [PW-1:0] r_tag_rptr;

  logic [31:0] r_tag_mem   [BUF_DEPTH];
  logic [31:0] r_fifo_data [BUF_DEPTH];
  logic [31:0] r_fifo_pc   [BUF_DEPTH];

  logic [CW:0]   w_occupancy;
  logic          w_req_valid;
  logic          w_fire;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_instr_valid;
  logic [CW-1:0] w_inflight_next;
  logic [31:0]   w_redirect_pc;
  logic          w_fault;

  // Every in-flight request owns a FIFO slot, so a response can always be written.
  assign w_occupancy     = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req_valid     = !reset && (w_occupancy < DEPTH_W) && !w_fault;
  assign w_fire          = w_req_valid && bus.imem_req_ready;
  assign w_resp          = bus.imem_resp_valid;
  // A response in the redirect cycle belongs to the old stream and is dropped.
  assign w_push          = w_resp && (r_drop_cnt == '0) && !bus.redirect_valid;
  assign w_instr_valid   = (r_count != '0);
  assign w_pop           = w_instr_valid && bus.instr_ready;
  assign w_inflight_next = r_inflight + CW'(w_fire) - CW'(w_resp);

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
      r_fault <= 1'b1;
    end
  end

  assign w_fault       = r_fault;
  assign w_redirect_pc = bus.redirect_pc;
`else
  logic w_unused_pc_lsb;

  assign w_fault         = 1'b0;
  assign w_redirect_pc   = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
    end else begin
      // A request firing in the redirect cycle used the old PC; it is part of
      // w_inflight_next and therefore counted as stale.
      if (bus.redirect_valid) begin
        r_pc <= w_redirect_pc;
      end else if (w_fire) begin
        r_pc <= r_pc + 32'd4;
      end

      r_inflight <= w_inflight_next;

      if (bus.redirect_valid) begin
        r_drop_cnt <= w_inflight_next;
      end else if (w_resp && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end

      // The tag queue is never flushed: dropped responses still pop their tag.
      if (w_fire) begin
        r_tag_wptr <= r_tag_wptr + PW'(1);
      end
      if (w_resp) begin
        r_tag_rptr <= r_tag_rptr + PW'(1);
      end

      if (bus.redirect_valid) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_fire) begin
      r_tag_mem[r_tag_wptr] <= r_pc;
    end
    if (w_push) begin
      r_fifo_data[r_wptr] <= bus.imem_resp_data;
      r_fifo_pc[r_wptr]   <= r_tag_mem[r_tag_rptr];
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = w_instr_valid;
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign bus.instruction    = w_instr_valid ? r_fifo_data[r_rptr] : 32'h0;
  assign bus.instr_pc       = w_instr_valid ? r_fifo_pc[r_rptr] : 32'h0;
  assign bus.fetch_fault    = w_fault;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'hFFFF_FFF8;
  localparam int          BUF_DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // memory model: in-order pending requests with their due cycle
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due;
  int          cyc;
  int          lat_min = 1, lat_max = 1;
  int          ready_pct = 100, instr_ready_pct = 100;

  // stream model: decode sees PC, PC+4, ... restarting at each redirect target
  logic [31:0] exp_req_pc, exp_dec_pc;
  logic [31:0] pop_log[$];
  logic        cyc_fire, cyc_resp, cyc_pop;
  int          n_fire, n_pop, first_pop_cyc;
  logic        redirect_req;
  logic [31:0] redirect_tgt;
  logic        prev_stall;
  logic [31:0] prev_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'h1234_5678) + {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] load_pc(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic clear_model();
    mem_addr_q.delete();
    mem_due_q.delete();
    pop_log.delete();
    last_due = 0;
    cyc = 0;
    exp_req_pc = RESET_PC;
    exp_dec_pc = RESET_PC;
    n_fire = 0;
    n_pop = 0;
    first_pop_cyc = -1;
    redirect_req = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic tick();
    int lat, due;
    @(negedge clock);
    cyc++;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = $urandom;
    cyc_resp = 1'b0;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = word_of(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
      cyc_resp = 1'b1;
    end
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.instr_ready    = ($urandom_range(99) < instr_ready_pct);
    bus.redirect_valid = redirect_req;
    bus.redirect_pc    = redirect_req ? redirect_tgt : $urandom;

    if (prev_stall) begin
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== prev_addr) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d valid=%b addr=%h expected valid=1 addr=%h",
                 cyc, bus.imem_req_valid, bus.imem_req_addr, prev_addr);
      end
    end

    cyc_fire = bus.imem_req_valid && bus.imem_req_ready;
    if (cyc_fire) begin
      checks++;
      if (bus.imem_req_addr !== exp_req_pc) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h expected=%h", cyc, bus.imem_req_addr, exp_req_pc);
      end
      exp_req_pc = exp_req_pc + 32'd4;
      n_fire++;
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr_q.push_back(bus.imem_req_addr);
      mem_due_q.push_back(due);
    end

    if (mem_addr_q.size() > BUF_DEPTH) begin
      checks++;
      errors++;
      $display("FAIL inflight_bound cyc=%0d got=%0d expected<=%0d", cyc, mem_addr_q.size(), BUF_DEPTH);
    end

    cyc_pop = bus.instr_valid && bus.instr_ready;
    if (cyc_pop) begin
      checks++;
      if (bus.instr_pc !== exp_dec_pc || bus.instruction !== word_of(exp_dec_pc)) begin
        errors++;
        $display("FAIL decode_word cyc=%0d got pc=%h insn=%h expected pc=%h insn=%h",
                 cyc, bus.instr_pc, bus.instruction, exp_dec_pc, word_of(exp_dec_pc));
      end
      pop_log.push_back(bus.instr_pc);
      exp_dec_pc = exp_dec_pc + 32'd4;
      n_pop++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end

    if (redirect_req) begin
      exp_req_pc = load_pc(redirect_tgt);
      exp_dec_pc = load_pc(redirect_tgt);
      redirect_req = 1'b0;
      pop_log.delete();
    end
    prev_stall = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
    prev_addr  = bus.imem_req_addr;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instruction !== 32'h0 ||
        bus.instr_pc !== 32'h0 || bus.fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL %s got req_valid=%b instr_valid=%b insn=%h pc=%h fault=%b expected all zero",
               tag, bus.imem_req_valid, bus.instr_valid, bus.instruction, bus.instr_pc, bus.fetch_fault);
    end
  endtask

  task automatic release_reset();
    clear_model();
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_request got valid=%b addr=%h expected valid=1 addr=%h",
               bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
  endtask

  // asynchronous reset asserted mid-cycle
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    repeat (2) @(negedge clock);
    release_reset();
  endtask

  task automatic set_env(input int lmin, input int lmax, input int rp, input int irp);
    lat_min = lmin; lat_max = lmax; ready_pct = rp; instr_ready_pct = irp;
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    int k = 0;
    while (n_pop < target && k < budget) begin
      tick();
      k++;
    end
    if (n_pop < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got pops=%0d expected>=%0d", tag, n_pop, target);
    end
  endtask

  task automatic test_reset();
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
    reset = 1'b1;
    #12 check_reset_outputs("reset_state");
    set_env(1, 1, 100, 100);
    release_reset();
  endtask

  // PC wrap FFFF_FFF8 -> FFFF_FFFC -> 0 is covered by the stream model here
  task automatic test_sequential();
    repeat (30) tick();
    checks++;
    if (first_pop_cyc !== 3) begin
      errors++;
      $display("FAIL first_word_latency got cycle=%0d expected=3", first_pop_cyc);
    end
    checks++;
    if (n_pop < 8) begin
      errors++;
      $display("FAIL seq_throughput got pops=%0d expected>=8", n_pop);
    end
    checks++;
    if (bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL midstream_valid got=%b expected=1", bus.instr_valid);
    end
    do_reset();
    repeat (4) tick();
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== RESET_PC) begin
      errors++;
      $display("FAIL restart_pc got=%h expected=%h", pop_log.size() ? pop_log[0] : 32'hX, RESET_PC);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_env(1, 1, 100, 0);
    repeat (10) tick();
    checks++;
    if (n_fire !== BUF_DEPTH) begin
      errors++;
      $display("FAIL bp_requests got=%0d expected=%0d", n_fire, BUF_DEPTH);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full got req_valid=%b instr_valid=%b expected req_valid=0 instr_valid=1",
               bus.imem_req_valid, bus.instr_valid);
    end
    set_env(1, 1, 100, 100);
    wait_pops(8, 40, "bp_release");
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    set_env(3, 3, 100, 100);
    repeat (2) tick();
    checks++;
    if (mem_addr_q.size() != 2) begin
      errors++;
      $display("FAIL rd_inflight got=%0d expected=2", mem_addr_q.size());
    end
    redirect_req = 1'b1;
    redirect_tgt = 32'h0000_0100;
    tick();
    wait_pops(n_pop + 3, 40, "rd_inflight");
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL rd_first_pc got=%h expected=%h", pop_log.size() ? pop_log[0] : 32'hX, 32'h100);
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    set_env(1, 1, 100, 100);
    tick();
    redirect_req = 1'b1;
    redirect_tgt = 32'h0000_0200;
    tick();
    checks++;
    if (!(cyc_fire && cyc_resp)) begin
      errors++;
      $display("FAIL coincide_setup got fire=%b resp=%b expected fire=1 resp=1", cyc_fire, cyc_resp);
    end
    wait_pops(n_pop + 2, 30, "coincide");
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h200) begin
      errors++;
      $display("FAIL coincide_first_pc got=%h expected=%h", pop_log.size() ? pop_log[0] : 32'hX, 32'h200);
    end
  endtask

  task automatic test_misaligned();
    int fires;
    do_reset();
    set_env(1, 1, 100, 100);
    repeat (3) tick();
    redirect_req = 1'b1;
    redirect_tgt = 32'h0000_0102;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    tick();
    checks++;
    if (bus.fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_set got=%b expected=1", bus.fetch_fault);
    end
    fires = n_fire;
    repeat (10) tick();
    checks++;
    if (n_fire != fires || bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_halt got new_fires=%0d req_valid=%b instr_valid=%b expected 0 0 0",
               n_fire - fires, bus.imem_req_valid, bus.instr_valid);
    end
`else
    fires = n_pop;
    wait_pops(fires + 2, 30, "misalign");
    checks++;
    if (bus.fetch_fault !== 1'b0 || pop_log.size() < 1 || pop_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL misalign_resume got fault=%b pc=%h expected fault=0 pc=%h",
               bus.fetch_fault, pop_log.size() ? pop_log[0] : 32'hX, 32'h100);
    end
`endif
  endtask

  task automatic test_random();
    int start;
    do_reset();
    set_env(1, 4, 70, 60);
    start = n_pop;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        start = n_pop - (start > 0 ? 0 : 0);
      end
      if ($urandom_range(39) == 0) begin
        redirect_req = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_tgt = $urandom & 32'hFFFF_FFFC;
`else
        redirect_tgt = $urandom;
`endif
      end
      tick();
    end
    checks++;
    if (n_pop < 200) begin
      errors++;
      $display("FAIL random_progress got pops=%0d expected>=200", n_pop);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_misaligned();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
